// File: rtl/fifo_rd_stream.sv
// Drains the synchronous FIFO into a valid/ready stream through a small credit-managed elastic buffer.
// Optional macro FIFO_RD_STATS_EN adds the 16-bit xfer_cnt handshake counter output.
module fifo_rd_stream #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BUF_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_r_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(BUF_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_CNT = (CW + 1)'(BUF_DEPTH);

    logic [WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    buf_cnt;
    logic             inflight;
    logic             handshake;
    logic [CW:0]      credits_used;

    // A pop is only issued when the word it returns is guaranteed a free slot.
    always_comb begin
        credits_used = {1'b0, buf_cnt} + {{CW{1'b0}}, inflight};
        fifo_r_en    = !rst && !fifo_empty && (credits_used < DEPTH_CNT);
        m_valid      = (buf_cnt != '0);
        m_data       = buf_mem[rd_ptr];
        handshake    = m_valid && m_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            buf_cnt  <= '0;
            inflight <= 1'b0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            inflight <= fifo_r_en;
            if (inflight) begin
                buf_mem[wr_ptr] <= fifo_data;
                wr_ptr          <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (handshake) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({inflight, handshake})
                2'b10:   buf_cnt <= buf_cnt + CW'(1);
                2'b01:   buf_cnt <= buf_cnt - CW'(1);
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (handshake) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: behavioural FIFO source, a cycle table, and directed corner sequences.
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_r_en;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] xfer_cnt;
`endif

    fifo_rd_stream #(.WIDTH(8), .BUF_DEPTH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_r_en  (fifo_r_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_STATS_EN
        ,
        .xfer_cnt   (xfer_cnt)
`endif
    );

    // Behavioural depth-8 FIFO with registered data_out; can be bulk-loaded or run as an endless counting source
    logic       load_req;
    logic [3:0] load_n;
    logic [7:0] load_words [8];
    logic       src_inf;
    logic [7:0] fmem [8];
    logic [2:0] frd;
    logic [3:0] fcnt;
    logic [7:0] fdout;

    always @(posedge clk) begin
        if (rst) begin
            frd   <= 3'd0;
            fcnt  <= 4'd0;
            fdout <= 8'd0;
        end else if (load_req) begin
            for (int i = 0; i < 8; i++) fmem[i] <= load_words[i];
            frd  <= 3'd0;
            fcnt <= load_n;
        end else if (fifo_r_en) begin
            if (src_inf) begin
                fdout <= fdout + 8'd1;
            end else if (fcnt != 4'd0) begin
                fdout <= fmem[frd];
                frd   <= frd + 3'd1;
                fcnt  <= fcnt - 4'd1;
            end
        end
    end
    assign fifo_empty = src_inf ? 1'b0 : (fcnt == 4'd0);
    assign fifo_data  = fdout;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct packed {
        logic       rst;
        logic       load;
        logic [7:0] word;
        logic       ready;
        logic       exp_ren;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs [22];
    logic [7:0] stream_words [8];
    logic [7:0] got [8];
    int         n;
    int         pops;
    int         extra;
    logic       unstable;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst, load, word, ready -> exp r_en, exp valid, exp data
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}; // FIFO non-empty, rst gates the pop
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[17] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h33};
        vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11}; // rd_ptr wrapped back to slot 0
        stream_words = '{8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};

        rst = 1'b1;
        m_ready = 1'b0;
        load_req = 1'b0;
        load_n = 4'd0;
        src_inf = 1'b0;
        for (int i = 0; i < 8; i++) load_words[i] = 8'h00;
        tick();
        tick();

        for (int i = 0; i < 22; i++) begin
            rst           = vecs[i].rst;
            load_req      = vecs[i].load;
            load_words[0] = vecs[i].word;
            load_n        = 4'd1;
            m_ready       = vecs[i].ready;
            #1;
            check($sformatf("vec%0d_r_en", i), fifo_r_en, vecs[i].exp_ren);
            check($sformatf("vec%0d_valid", i), m_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_data", i), m_data, vecs[i].exp_data);
            tick();
        end
        load_req = 1'b0;

        // Full FIFO streamed with m_ready high: eight back-to-back words
        load_words = stream_words;
        load_n = 4'd8;
        load_req = 1'b1;
        m_ready = 1'b1;
        tick();
        load_req = 1'b0;
        for (int c = 0; c < 10 && !m_valid; c++) tick();
        check("stream_start", m_valid, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream_valid%0d", i), m_valid, 1'b1);
            check($sformatf("stream_data%0d", i), m_data, stream_words[i]);
            tick();
        end
        check("stream_end_valid", m_valid, 1'b0);
        check("stream_fifo_cnt", fcnt, 4'd0);

        // Backpressure: only BUF_DEPTH pops while m_ready is low
        for (int i = 0; i < 8; i++) load_words[i] = 8'h80 + 8'(i);
        load_req = 1'b1;
        m_ready = 1'b0;
        pops = 0;
        unstable = 1'b0;
        for (int c = 0; c < 11; c++) begin
            #1;
            if (fifo_r_en) pops++;
            if (m_valid && m_data !== 8'h80) unstable = 1'b1;
            tick();
            load_req = 1'b0;
        end
        check("bp_pops", 16'(pops), 16'd3);
        check("bp_fifo_cnt", fcnt, 4'd5);
        check("bp_valid", m_valid, 1'b1);
        check("bp_data", m_data, 8'h80);
        check("bp_stable", unstable, 1'b0);
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            #1;
            if (m_valid) begin
                got[n] = m_data;
                n++;
            end
            tick();
        end
        check("bp_count", 16'(n), 16'd8);
        for (int i = 0; i < 8; i++) check($sformatf("bp_order%0d", i), got[i], 8'h80 + 8'(i));
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            if (m_valid) extra++;
            tick();
        end
        check("bp_no_extra", 16'(extra), 16'd0);
        check("bp_fifo_drained", fcnt, 4'd0);

        // Reset while one word is in flight and two are buffered
        for (int i = 0; i < 8; i++) load_words[i] = 8'hC0 + 8'(i);
        load_req = 1'b1;
        m_ready = 1'b0;
        tick();
        load_req = 1'b0;
        #1;
        check("mr_c1_r_en", fifo_r_en, 1'b1);
        tick();
        tick();
        check("mr_c3_r_en", fifo_r_en, 1'b1);
        check("mr_c3_valid", m_valid, 1'b1);
        tick();
        check("mr_c4_r_en", fifo_r_en, 1'b0);
        check("mr_c4_data", m_data, 8'hC0);
        rst = 1'b1;
        #1;
        check("mr_rst_r_en", fifo_r_en, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("mr_post_valid", m_valid, 1'b0);
        check("mr_post_data", m_data, 8'h00);
        check("mr_post_r_en", fifo_r_en, 1'b0);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            if (m_valid) extra++;
            tick();
        end
        check("mr_no_ghost", 16'(extra), 16'd0);
        load_words[0] = 8'hA5;
        load_n = 4'd1;
        load_req = 1'b1;
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (m_valid) begin
                if (n < 8) got[n] = m_data;
                n++;
            end
            tick();
            load_req = 1'b0;
        end
        check("mr_fresh_count", 16'(n), 16'd1);
        check("mr_fresh_data", got[0], 8'hA5);

`ifdef FIFO_RD_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("stats_reset", xfer_cnt, 16'd0);
        src_inf = 1'b1;
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 70000 && n < 65539; c++) begin
            if (m_valid) n++;
            tick();
        end
        m_ready = 1'b0;
        src_inf = 1'b0;
        check("stats_hs_reached", 16'(n == 65539), 16'd1);
        check("stats_wrap", xfer_cnt, 16'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("stats_clear", xfer_cnt, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
